// File: rtl/alu_seq_pkg.sv
// Shared opcodes, ALU encodings, FSM states and strobe bundle for the
// register-file/ALU datapath sequencer.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_MOVI = 3'b100;
  localparam logic [2:0] OP_CMP  = 3'b101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  typedef struct packed {
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       loadc;
    logic       loads;
    logic       write;
    logic       vsel;
    logic       done;
    logic [1:0] alu_op;
  } strobe_t;

  // First state after accept; reserved opcodes complete without touching the datapath.
  function automatic state_t entry_state(input logic [2:0] op);
    state_t s;
    s = S_DONE;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_CMP: s = S_RD_A;
      OP_NOT:                         s = S_RD_B;
      OP_MOVI:                        s = S_WB;
      default:                        s = S_DONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Moore strobe decoder: current state plus latched opcode/setflags to the
// datapath control strobes. Purely combinational.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  state_t     state,
  input  logic [2:0] op,
  input  logic       setflags,
  output strobe_t    strobes
);

  always_comb begin
    strobes = '0;
    case (state)
      S_RD_A: strobes.loada = 1'b1;
      S_RD_B: strobes.loadb = 1'b1;
      S_EXEC: begin
        strobes.loadc = 1'b1;
        strobes.loads = setflags;
        case (op)
          OP_NOT: begin
            strobes.asel   = 1'b1;
            strobes.alu_op = ALU_NOT;
          end
          // CMP only exists to update the flags, so loads is forced.
          OP_CMP: begin
            strobes.alu_op = ALU_SUB;
            strobes.loads  = 1'b1;
          end
          default: strobes.alu_op = op[1:0];
        endcase
      end
      S_WB: begin
        strobes.write = 1'b1;
        strobes.vsel  = (op == OP_MOVI);
      end
      S_DONE:  strobes.done = 1'b1;
      default: strobes = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle control FSM for the 16-bit register-file/ALU datapath:
// accepts one command over valid/ready and steps the datapath strobes.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int REG_AW = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_rn,
  input  logic [REG_AW-1:0] cmd_rm,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic              cmd_setflags,
  output logic [REG_AW-1:0] readnum,
  output logic [REG_AW-1:0] writenum,
  output logic              write,
  output logic              vsel,
  output logic [DATA_W-1:0] imm_out,
  output logic              loada,
  output logic              loadb,
  output logic              asel,
  output logic              loadc,
  output logic              loads,
  output logic [1:0]        alu_op,
  output logic              done,
  output logic              busy
);

  state_t            state, state_nxt;
  logic [2:0]        op_q;
  logic [REG_AW-1:0] rd_q, rn_q, rm_q;
  logic [DATA_W-1:0] imm_q;
  logic              setflags_q;
  logic              accept;
  strobe_t           strobes;

  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // The in-flight command is frozen here so later input changes cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      rd_q       <= '0;
      rn_q       <= '0;
      rm_q       <= '0;
      imm_q      <= '0;
      setflags_q <= 1'b0;
    end else if (accept) begin
      op_q       <= cmd_op;
      rd_q       <= cmd_rd;
      rn_q       <= cmd_rn;
      rm_q       <= cmd_rm;
      imm_q      <= cmd_imm;
      setflags_q <= cmd_setflags;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_nxt = entry_state(cmd_op);
      S_RD_A:  state_nxt = S_RD_B;
      S_RD_B:  state_nxt = S_EXEC;
      S_EXEC:  state_nxt = (op_q == OP_CMP) ? S_DONE : S_WB;
      S_WB:    state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  alu_seq_decode u_decode (
    .state    (state),
    .op       (op_q),
    .setflags (setflags_q),
    .strobes  (strobes)
  );

  always_comb begin
    readnum  = '0;
    writenum = '0;
    if (state == S_RD_A) readnum = rn_q;
    if (state == S_RD_B) readnum = rm_q;
    if (state == S_WB)   writenum = rd_q;
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign imm_out   = imm_q;
  assign loada     = strobes.loada;
  assign loadb     = strobes.loadb;
  assign asel      = strobes.asel;
  assign loadc     = strobes.loadc;
  assign loads     = strobes.loads;
  assign write     = strobes.write;
  assign vsel      = strobes.vsel;
  assign done      = strobes.done;
  assign alu_op    = strobes.alu_op;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer: per-cycle strobe traces for each
// opcode, back-to-back handshake and asynchronous reset mid-operation.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_rd, cmd_rn, cmd_rm;
  logic [15:0] cmd_imm;
  logic        cmd_setflags;
  logic [2:0]  readnum, writenum;
  logic        write, vsel, loada, loadb, asel, loadc, loads, done, busy;
  logic [15:0] imm_out;
  logic [1:0]  alu_op;

  int errors = 0;
  int checks = 0;

  alu_op_sequencer #(.REG_AW(3), .DATA_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_rd       (cmd_rd),
    .cmd_rn       (cmd_rn),
    .cmd_rm       (cmd_rm),
    .cmd_imm      (cmd_imm),
    .cmd_setflags (cmd_setflags),
    .readnum      (readnum),
    .writenum     (writenum),
    .write        (write),
    .vsel         (vsel),
    .imm_out      (imm_out),
    .loada        (loada),
    .loadb        (loadb),
    .asel         (asel),
    .loadc        (loadc),
    .loads        (loads),
    .alu_op       (alu_op),
    .done         (done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Packed view: {loada,loadb,loadc,loads,write,vsel,asel,done,busy,cmd_ready,alu_op,readnum,writenum}
  function automatic logic [17:0] vec(input logic la, lb, lc, ls, wr, vs, as_, dn, bz, rdy,
                                      input logic [1:0] aop, input logic [2:0] rnum, wnum);
    return {la, lb, lc, ls, wr, vs, as_, dn, bz, rdy, aop, rnum, wnum};
  endfunction

  function automatic logic [17:0] observed();
    return {loada, loadb, loadc, loads, write, vsel, asel, done, busy, cmd_ready,
            alu_op, readnum, writenum};
  endfunction

  localparam logic [17:0] IDLE_V = 18'b0000_0000_01_00_000_000;

  // Strobe exclusivity holds on every clock while out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if ($countones({loada, loadb, loadc, write}) > 1 || (loads && !loadc)) begin
        errors++;
        $display("[TB] FAIL strobe_exclusive t=%0t got la=%b lb=%b lc=%b ls=%b wr=%b expected at most one, loads only with loadc",
                 $time, loada, loadb, loadc, loads, write);
      end
    end
  end

  // Present a command and return one sample point after the accepting edge (cycle 1).
  task automatic issue(input logic [2:0] op, input logic [2:0] rd, rn, rm,
                       input logic [15:0] imm, input logic sf);
    @(negedge clk);
    cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm;
    cmd_imm = imm; cmd_setflags = sf; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rn = '0;
    cmd_rm = '0; cmd_imm = '0; cmd_setflags = 1'b0;
    #3;
    checks++;
    if ({write, busy, done, loada, loadb, loadc, loads, vsel, asel} !== 9'b0) begin
      errors++;
      $display("[TB] FAIL reset_strobes got %b expected 000000000",
               {write, busy, done, loada, loadb, loadc, loads, vsel, asel});
    end
    checks++;
    if ({readnum, writenum, alu_op, imm_out} !== 24'h0) begin
      errors++;
      $display("[TB] FAIL reset_fields got %h expected 000000", {readnum, writenum, alu_op, imm_out});
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (observed() !== IDLE_V) begin
      errors++;
      $display("[TB] FAIL reset_release got %h expected %h", observed(), IDLE_V);
    end
  endtask

  task automatic test_add();
    logic [17:0] e [1:6];
    e[1] = vec(1,0,0,0,0,0,0,0,1,0,2'b00,3'd1,3'd0);
    e[2] = vec(0,1,0,0,0,0,0,0,1,0,2'b00,3'd2,3'd0);
    e[3] = vec(0,0,1,1,0,0,0,0,1,0,2'b00,3'd0,3'd0);
    e[4] = vec(0,0,0,0,1,0,0,0,1,0,2'b00,3'd0,3'd3);
    e[5] = vec(0,0,0,0,0,0,0,1,1,0,2'b00,3'd0,3'd0);
    e[6] = IDLE_V;
    issue(3'b000, 3'd3, 3'd1, 3'd2, 16'h0000, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      checks++;
      if (observed() !== e[k]) begin
        errors++;
        $display("[TB] FAIL add_c%0d got %h expected %h", k, observed(), e[k]);
      end
    end
  endtask

  task automatic test_and_noflags();
    logic [17:0] e [1:6];
    e[1] = vec(1,0,0,0,0,0,0,0,1,0,2'b00,3'd6,3'd0);
    e[2] = vec(0,1,0,0,0,0,0,0,1,0,2'b00,3'd7,3'd0);
    e[3] = vec(0,0,1,0,0,0,0,0,1,0,2'b10,3'd0,3'd0);
    e[4] = vec(0,0,0,0,1,0,0,0,1,0,2'b00,3'd0,3'd2);
    e[5] = vec(0,0,0,0,0,0,0,1,1,0,2'b00,3'd0,3'd0);
    e[6] = IDLE_V;
    issue(3'b010, 3'd2, 3'd6, 3'd7, 16'h0000, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      checks++;
      if (observed() !== e[k]) begin
        errors++;
        $display("[TB] FAIL and_c%0d got %h expected %h", k, observed(), e[k]);
      end
    end
  endtask

  task automatic test_not();
    logic [17:0] e [1:5];
    e[1] = vec(0,1,0,0,0,0,0,0,1,0,2'b00,3'd5,3'd0);
    e[2] = vec(0,0,1,1,0,0,1,0,1,0,2'b11,3'd0,3'd0);
    e[3] = vec(0,0,0,0,1,0,0,0,1,0,2'b00,3'd0,3'd0);
    e[4] = vec(0,0,0,0,0,0,0,1,1,0,2'b00,3'd0,3'd0);
    e[5] = IDLE_V;
    issue(3'b011, 3'd0, 3'd6, 3'd5, 16'h0000, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      checks++;
      if (observed() !== e[k]) begin
        errors++;
        $display("[TB] FAIL not_c%0d got %h expected %h", k, observed(), e[k]);
      end
    end
  endtask

  task automatic test_cmp();
    logic [17:0] e [1:5];
    e[1] = vec(1,0,0,0,0,0,0,0,1,0,2'b00,3'd4,3'd0);
    e[2] = vec(0,1,0,0,0,0,0,0,1,0,2'b00,3'd4,3'd0);
    e[3] = vec(0,0,1,1,0,0,0,0,1,0,2'b01,3'd0,3'd0);
    e[4] = vec(0,0,0,0,0,0,0,1,1,0,2'b00,3'd0,3'd0);
    e[5] = IDLE_V;
    issue(3'b101, 3'd1, 3'd4, 3'd4, 16'h0000, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      checks++;
      if (observed() !== e[k]) begin
        errors++;
        $display("[TB] FAIL cmp_c%0d got %h expected %h", k, observed(), e[k]);
      end
    end
  endtask

  task automatic test_movi();
    logic [17:0] e [1:3];
    e[1] = vec(0,0,0,0,1,1,0,0,1,0,2'b00,3'd0,3'd7);
    e[2] = vec(0,0,0,0,0,0,0,1,1,0,2'b00,3'd0,3'd0);
    e[3] = IDLE_V;
    issue(3'b100, 3'd7, 3'd0, 3'd0, 16'h00A5, 1'b1);
    cmd_imm = 16'hFFFF;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      checks++;
      if (observed() !== e[k]) begin
        errors++;
        $display("[TB] FAIL movi_c%0d got %h expected %h", k, observed(), e[k]);
      end
      checks++;
      if (imm_out !== 16'h00A5) begin
        errors++;
        $display("[TB] FAIL movi_imm_c%0d got %h expected 00a5", k, imm_out);
      end
    end
  endtask

  task automatic test_reserved();
    logic [17:0] e [1:2];
    e[1] = vec(0,0,0,0,0,0,0,1,1,0,2'b00,3'd0,3'd0);
    e[2] = IDLE_V;
    issue(3'b111, 3'd5, 3'd3, 3'd2, 16'h0000, 1'b1);
    for (int k = 1; k <= 2; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      checks++;
      if (observed() !== e[k]) begin
        errors++;
        $display("[TB] FAIL reserved_c%0d got %h expected %h", k, observed(), e[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] e [1:12];
    e[1]  = vec(1,0,0,0,0,0,0,0,1,0,2'b00,3'd1,3'd0);
    e[2]  = vec(0,1,0,0,0,0,0,0,1,0,2'b00,3'd2,3'd0);
    e[3]  = vec(0,0,1,1,0,0,0,0,1,0,2'b00,3'd0,3'd0);
    e[4]  = vec(0,0,0,0,1,0,0,0,1,0,2'b00,3'd0,3'd3);
    e[5]  = vec(0,0,0,0,0,0,0,1,1,0,2'b00,3'd0,3'd0);
    e[6]  = IDLE_V;
    e[7]  = vec(1,0,0,0,0,0,0,0,1,0,2'b00,3'd5,3'd0);
    e[8]  = vec(0,1,0,0,0,0,0,0,1,0,2'b00,3'd6,3'd0);
    e[9]  = vec(0,0,1,1,0,0,0,0,1,0,2'b01,3'd0,3'd0);
    e[10] = vec(0,0,0,0,1,0,0,0,1,0,2'b00,3'd0,3'd4);
    e[11] = vec(0,0,0,0,0,0,0,1,1,0,2'b00,3'd0,3'd0);
    e[12] = IDLE_V;
    @(negedge clk);
    cmd_op = 3'b000; cmd_rd = 3'd3; cmd_rn = 3'd1; cmd_rm = 3'd2;
    cmd_imm = 16'h0000; cmd_setflags = 1'b1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_op = 3'b001; cmd_rd = 3'd4; cmd_rn = 3'd5; cmd_rm = 3'd6;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k == 7) cmd_valid = 1'b0;
      checks++;
      if (observed() !== e[k]) begin
        errors++;
        $display("[TB] FAIL b2b_c%0d got %h expected %h", k, observed(), e[k]);
      end
    end
  endtask

  task automatic test_reset_mid_wb();
    issue(3'b000, 3'd3, 3'd1, 3'd2, 16'h1234, 1'b1);
    for (int k = 2; k <= 4; k++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (write !== 1'b1 || writenum !== 3'd3) begin
      errors++;
      $display("[TB] FAIL rst_wb_entry got write=%b writenum=%0d expected write=1 writenum=3", write, writenum);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({write, busy, done} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL rst_async got write/busy/done=%b expected 000", {write, busy, done});
    end
    checks++;
    if ({writenum, imm_out} !== 19'h0) begin
      errors++;
      $display("[TB] FAIL rst_async_fields got writenum=%0d imm_out=%h expected 0 and 0000", writenum, imm_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (observed() !== IDLE_V) begin
      errors++;
      $display("[TB] FAIL rst_release got %h expected %h", observed(), IDLE_V);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_and_noflags();
    test_not();
    test_cmp();
    test_movi();
    test_reserved();
    test_back_to_back();
    test_reset_mid_wb();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
